// File: rtl/uart_display_soc.sv
// Board-level top: 8N1 UART receiver -> 8-bit LED display register, with an optional
// 8N1 echo transmitter and one-entry holding register (enabled by macro UART_ECHO_EN).
module uart_display_soc #(
   parameter int CLKS_PER_BIT   = 868,
   parameter int RX_SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_i,
   output logic [7:0] display_o,
   input  logic       rx_i,
   output logic       tx_o
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   // ---------------- rx synchronizer ----------------
   logic [RX_SYNC_STAGES-1:0] sync_q;
   logic                      rxs;

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) sync_q <= '1;
      else          sync_q <= {sync_q[RX_SYNC_STAGES-2:0], rx_i};
   end
   assign rxs = sync_q[RX_SYNC_STAGES-1];

   // ---------------- receiver ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   rx_state_t       rx_state, rx_state_n;
   logic [CW-1:0]   rx_cnt, rx_cnt_n;
   logic [2:0]      rx_bit, rx_bit_n;
   logic [7:0]      rx_sh, rx_sh_n;
   logic            rx_ferr, rx_ferr_n;
   logic            rx_valid, rx_valid_n;

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         rx_ferr  <= 1'b0;
         rx_valid <= 1'b0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
         rx_ferr  <= rx_ferr_n;
         rx_valid <= rx_valid_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt + CW'(1);
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      rx_ferr_n  = rx_ferr;
      rx_valid_n = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (!rxs) rx_state_n = RX_START;
         end
         RX_START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rxs ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_n = '0;
               rx_sh_n  = {rxs, rx_sh[7:1]};
               rx_bit_n = rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            // after a framing error, linger here until the line returns high
            if (rx_ferr) begin
               rx_cnt_n = '0;
               if (rxs) begin
                  rx_ferr_n  = 1'b0;
                  rx_state_n = RX_IDLE;
               end
            end else if (rx_cnt == BIT_LAST) begin
               rx_cnt_n = '0;
               if (rxs) begin
                  rx_valid_n = 1'b1;
                  rx_state_n = RX_IDLE;
               end else begin
                  rx_ferr_n = 1'b1;
               end
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   // ---------------- display register ----------------
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i)      display_o <= 8'h00;
      else if (rx_valid) display_o <= rx_sh;
   end

`ifdef UART_ECHO_EN
   // ---------------- echo transmitter ----------------
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   tx_state_t       tx_state, tx_state_n;
   logic [CW-1:0]   tx_cnt, tx_cnt_n;
   logic [2:0]      tx_bit, tx_bit_n;
   logic [7:0]      tx_sh, tx_sh_n;
   logic [7:0]      hold, hold_n;
   logic            hold_full, hold_full_n;
   logic            tx_q, tx_q_n;
   logic            rx_taken;

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         tx_state  <= TX_IDLE;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_sh     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         tx_state  <= tx_state_n;
         tx_cnt    <= tx_cnt_n;
         tx_bit    <= tx_bit_n;
         tx_sh     <= tx_sh_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
         tx_q      <= tx_q_n;
      end
   end

   always_comb begin
      tx_state_n  = tx_state;
      tx_cnt_n    = tx_cnt + CW'(1);
      tx_bit_n    = tx_bit;
      tx_sh_n     = tx_sh;
      hold_n      = hold;
      hold_full_n = hold_full;
      rx_taken    = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_cnt_n = '0;
            if (rx_valid) begin
               tx_sh_n    = rx_sh;
               rx_taken   = 1'b1;
               tx_state_n = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n   = '0;
               tx_bit_n   = '0;
               tx_state_n = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n = '0;
               tx_sh_n  = {1'b0, tx_sh[7:1]};
               tx_bit_n = tx_bit + 3'd1;
               if (tx_bit == 3'd7) tx_state_n = TX_STOP;
            end
         end
         TX_STOP: begin
            // chain straight into the next frame so echoes go out back-to-back
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n   = '0;
               tx_state_n = TX_IDLE;
               if (hold_full) begin
                  tx_sh_n     = hold;
                  hold_full_n = 1'b0;
                  tx_state_n  = TX_START;
               end else if (rx_valid) begin
                  tx_sh_n    = rx_sh;
                  rx_taken   = 1'b1;
                  tx_state_n = TX_START;
               end
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
      if (rx_valid && !rx_taken && !hold_full_n) begin
         hold_n      = rx_sh;
         hold_full_n = 1'b1;
      end
      case (tx_state_n)
         TX_START: tx_q_n = 1'b0;
         TX_DATA:  tx_q_n = tx_sh_n[0];
         default:  tx_q_n = 1'b1;
      endcase
   end

   assign tx_o = tx_q;
`else
   assign tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_uart_display_soc.sv
// Directed bench for uart_display_soc: byte-level display/echo model plus a serial tx decoder.
module tb_uart_display_soc;
   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset_i;
   logic       rx_i;
   logic       tx_o;
   logic [7:0] display_o;

   always #5 clk = ~clk;

   uart_display_soc #(.CLKS_PER_BIT(CPB), .RX_SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset_i   (reset_i),
      .display_o (display_o),
      .rx_i      (rx_i),
      .tx_o      (tx_o)
   );

   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_disp = 8'h00;
   bit         dc = 1'b0;          // display may be mid-update during a stop bit
   logic [7:0] echo_q[$];
   bit         tm_active = 1'b0;
   int         tm_cnt = 0;
   logic [9:0] tm_frame = '0;
   logic [9:0] last_frame = '0;
   int         frames_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // every-cycle compare of the display (and idle tx line when echo is not built)
   initial forever begin
      @(negedge clk);
      if (reset_i === 1'b1 && !dc) begin
         chk("display", display_o, exp_disp);
`ifndef UART_ECHO_EN
         chk("tx_idle", tx_o, 1);
`endif
      end
   end

   // serial decoder for tx_o: finds start bits, samples mid-bit, checks against echo queue
   initial forever begin
      @(negedge clk);
      if (reset_i !== 1'b1) begin
         tm_active = 1'b0;
      end else if (!tm_active) begin
         if (tx_o === 1'b0) begin
            tm_active = 1'b1;
            tm_cnt    = 0;
            tm_frame  = '0;
         end
      end else begin
         tm_cnt++;
         if (tm_cnt % CPB == CPB / 2) begin
            tm_frame[tm_cnt / CPB] = tx_o;
            if (tm_cnt / CPB == 9) begin
               tm_active = 1'b0;
               chk("tx_start_bit", tm_frame[0], 0);
               chk("tx_stop_bit", tm_frame[9], 1);
               if (echo_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL tx_frame: got byte %0h expected no frame", tm_frame[8:1]);
               end else begin
                  chk("tx_byte", tm_frame[8:1], echo_q.pop_front());
               end
               last_frame = tm_frame;
               frames_seen++;
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic bit_time(input logic v, input int nbits);
      rx_i = v;
      cycles(nbits * CPB);
   endtask

   task automatic send(input logic [7:0] b, input bit stop_ok);
      bit_time(1'b0, 1);
      for (int i = 0; i < 8; i++) bit_time(b[i], 1);
      if (stop_ok) begin
         dc = 1'b1;
`ifdef UART_ECHO_EN
         echo_q.push_back(b);
`endif
         bit_time(1'b1, 1);
         exp_disp = b;
         dc = 1'b0;
      end else begin
         bit_time(1'b0, 2);
         bit_time(1'b1, 2);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((echo_q.size() != 0 || tm_active) && n < 3000) begin
         cycles(1);
         n++;
      end
      chk("drain_timeout", (n >= 3000), 0);
   endtask

   initial begin
      rx_i    = 1'b1;
      reset_i = 1'b0;
      #3;
      chk("reset_display", display_o, 8'h00);
      chk("reset_tx", tx_o, 1);
      #19;
      reset_i = 1'b1;
      @(negedge clk);
      #1;

      // long idle line
      cycles(10000);
      chk("idle_display", display_o, 8'h00);
      chk("idle_tx", tx_o, 1);

      // single byte
      send(8'hA5, 1'b1);
      chk("disp_A5", display_o, 8'hA5);
      drain();
`ifdef UART_ECHO_EN
      chk("frame_A5", last_frame, 10'b1101001010);
`endif

      // back-to-back bytes
      send(8'h3C, 1'b1);
      send(8'h81, 1'b1);
      send(8'hFF, 1'b1);
      chk("disp_FF", display_o, 8'hFF);
      drain();

      // one-cycle glitch is a false start
      rx_i = 1'b0;
      cycles(1);
      rx_i = 1'b1;
      cycles(64);
      chk("glitch_display", display_o, 8'hFF);

      // framing error then a good byte
      send(8'h55, 1'b0);
      cycles(32);
      chk("ferr_display", display_o, 8'hFF);
      send(8'h0F, 1'b1);
      chk("disp_0F", display_o, 8'h0F);
      drain();

      // reset while receiving the next byte and echoing this one
      send(8'h77, 1'b1);
      bit_time(1'b0, 1);
      bit_time(1'b1, 1);
      bit_time(1'b0, 1);
      reset_i  = 1'b0;
      rx_i     = 1'b1;
      exp_disp = 8'h00;
      echo_q.delete();
      #1;
      chk("midreset_display", display_o, 8'h00);
      chk("midreset_tx", tx_o, 1);
      cycles(3);
      reset_i = 1'b1;
      cycles(32);
      send(8'h42, 1'b1);
      chk("disp_42", display_o, 8'h42);
      drain();
`ifdef UART_ECHO_EN
      chk("frame_count", frames_seen, 6);
`else
      chk("frame_count", frames_seen, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_display_soc.md
Name: uart_display_soc

Overview:
- Minimal stand-alone SoC top: an 8N1 UART receiver, an 8-bit display register and an 8N1 UART transmitter.
- Each byte received on rx_i is latched onto display_o and, optionally, echoed back on tx_o.
- It is the board-level top: clock from the oscillator, reset from a button, LEDs on display_o, UART pins on rx_i/tx_o.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Must be at least 4.
- RX_SYNC_STAGES, 2, flip-flop stages in the rx_i synchronizer (2..3).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_i  in  1  asynchronous, active-low reset (0 = reset).
- display_o  out  8  display register (LEDs).
- rx_i  in  1  UART serial input, idle high, asynchronous to clk.
- tx_o  out  1  UART serial output, idle high.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset asserted (reset_i=0), effective immediately:
  - display_o=8'h00, tx_o=1.
  - RX and TX FSMs go to IDLE; bit and baud counters clear; echo holding register empty.
  - Synchronizer flops preset to 1.
  - Any frame in progress is aborted, with no partial display update.
- rx_i passes through RX_SYNC_STAGES flops; all RX decisions use the synchronized value rxs.
- RX FSM, IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: rxs==0 starts the baud counter and enters START.
  - START: sample at CLKS_PER_BIT/2 (integer division). If rxs==1, false start: return to IDLE. Otherwise go to DATA.
  - DATA: 8 samples, each CLKS_PER_BIT cycles after the previous, shifted in LSB first.
  - STOP: sample CLKS_PER_BIT after bit 7.
    - rxs==1: assert rx_valid for exactly one cycle with the byte, then go to IDLE.
    - rxs==0: framing error. Discard the byte (no valid), stay in STOP until rxs==1, then go to IDLE.
  - A new start bit is accepted from the cycle after returning to IDLE.
- Display: on the clock edge after rx_valid, display_o <= received byte. It holds until the next valid byte or reset. No other source writes it.
- TX FSM, IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: tx_o=1.
  - START: tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles.
  - Returning from STOP, TX loads the holding register immediately if it is full, so frames are back-to-back.
  - tx_o is driven from a register (glitch-free).
- Echo queue, one-entry holding register:
  - On rx_valid: if TX is IDLE and the holding register is empty, the start bit begins on the next cycle. Otherwise, if the holding register is empty, the byte is stored there.
  - If the holding register is full, the echo of the new byte is dropped; display_o still updates.
  - Simultaneous rx_valid and TX finishing STOP: the held byte transmits first and the new byte takes the holding register.
- Latency, from the clock edge that samples the valid stop bit:
  - display_o updates 1 cycle later.
  - tx_o start bit begins 1 cycle later if TX is idle.
- With rx_i constantly high, display_o stays 8'h00 and tx_o stays 1 indefinitely.

Optional Feature:
- Macro UART_ECHO_EN.
- Defined: the TX FSM and holding register are present and echo as above.
- Undefined: no TX logic is built; tx_o is tied to constant 1; the RX and display behaviour is unchanged.

Test Plan:
- Hold reset_i=0 for 20 ns, then release; rx_i idle high for 100 us -> display_o=8'h00 and tx_o=1 throughout.
- CLKS_PER_BIT=16: send 0xA5 8N1 -> display_o=8'hA5 one cycle after the stop sample; with UART_ECHO_EN, tx_o carries frame 0xA5 (0,1,0,1,0,0,1,0,1,1), 16 cycles per bit.
- Send 0x3C, 0x81, 0xFF back-to-back -> display_o ends at 8'hFF; the echoes 0x3C, 0x81 and 0xFF are all transmitted in order.
- 1-cycle low glitch on rx_i, then high -> false start; display_o unchanged; no tx activity.
- Frame 0x55 with stop bit held low for 2 bit times -> byte discarded, display_o unchanged; the next valid 0x0F shows 8'h0F.
- Assert reset_i low mid-frame on both RX and TX -> display_o=8'h00 and tx_o=1 immediately; a subsequent clean 0x42 is received and echoed correctly.
